// File: rtl/ptmch_spi_resp.sv
`default_nettype none
// ============================================================================
// Module   : ptmch_spi_resp
// Brief    : SPI-NAND responder (mode 0, MSB first) modelling the status
//            register and identification subset of the flash command set.
//            Decodes Read/Write Status, WEL set/clear and, optionally, Read ID.
// Options  : define PTMCH_SPI_RESP_JEDEC_EN to build Read ID (opcode 9Fh).
// Revision : 1.0 - initial release
// ============================================================================
module ptmch_spi_resp #(
    parameter logic [7:0]  P_MFR_ID   = 8'hEF,
    parameter logic [15:0] P_DEV_ID   = 16'hAA21,
    parameter logic [7:0]  P_PROT_RST = 8'h7C,
    parameter logic [7:0]  P_CFG_RST  = 8'h18
) (
    input  logic       RESET_N,
    input  logic       SPI_CLK,
    input  logic       SPI_CS,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic       SPI_MISO_OE,
    input  logic       BUSY,
    output logic [7:0] PROT_REG,
    output logic [7:0] CFG_REG,
    output logic       WR_STB,
    output logic [7:0] WR_ADDR
);

    localparam logic [7:0] c_ADDR_PROT = 8'hA0;
    localparam logic [7:0] c_ADDR_CFG  = 8'hB0;
    localparam logic [7:0] c_ADDR_STAT = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_WDATA    = 3'd2,
        ST_RDATA    = 3'd3,
        ST_ID_DUMMY = 3'd4,
        ST_ID_OUT   = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_rx;
    logic [7:0]  r_addr;
    logic [7:0]  r_tx;
    logic        r_is_write;
    logic        r_wr_stb;
    logic [7:0]  r_prot;
    logic [7:0]  r_cfg;
    logic        r_wel;
    logic [7:0]  r_wr_addr;
    logic        r_miso;
    logic        r_miso_oe;

    logic        w_frame_rst_n;
    logic [7:0]  w_byte;
    logic        w_byte_done;
    logic [7:0]  w_rd_addr;
    logic [7:0]  w_rd_val;
    logic        w_wel_set;
    logic        w_wel_clr;
    logic        w_reg_wr;
    logic        w_tx_load;
    logic [7:0]  w_tx_val;
    logic        w_tx_active;
    logic        w_rx_msb_unused;

`ifdef PTMCH_SPI_RESP_JEDEC_EN
    logic [1:0]  r_id_idx;
`else
    logic        w_id_unused;
    assign w_id_unused = ^{P_MFR_ID, P_DEV_ID};
`endif

    // Frame-scoped state is cleared by reset or by a deselected chip.
    assign w_frame_rst_n   = RESET_N & ~SPI_CS;

    // Byte assembled at the current rising edge, completes every 8th clock.
    assign w_byte          = {r_rx[6:0], SPI_MOSI};
    assign w_byte_done     = (r_bit_cnt == 3'd7);
    // The oldest RX bit falls out of the window as the next byte completes.
    assign w_rx_msb_unused = r_rx[7];

    // Register read mux; the address byte is still arriving while in ADDR.
    always_comb begin
        w_rd_addr = (r_state == ST_ADDR) ? w_byte : r_addr;
        case (w_rd_addr)
            c_ADDR_PROT: w_rd_val = r_prot;
            c_ADDR_CFG:  w_rd_val = r_cfg;
            c_ADDR_STAT: w_rd_val = {6'b0, r_wel, BUSY};
            default:     w_rd_val = 8'h00;
        endcase
    end

    // Next-state decode and the per-byte control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_wel_set   = 1'b0;
        w_wel_clr   = 1'b0;
        w_reg_wr    = 1'b0;
        w_tx_load   = 1'b0;
        w_tx_val    = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_done) begin
                    case (w_byte)
                        8'h0F, 8'h05, 8'h1F, 8'h01: w_state_nxt = ST_ADDR;
                        8'h06: begin
                            w_wel_set   = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
                        8'h04: begin
                            w_wel_clr   = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
`ifdef PTMCH_SPI_RESP_JEDEC_EN
                        8'h9F: w_state_nxt = ST_ID_DUMMY;
`endif
                        default: w_state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_ADDR: begin
                if (w_byte_done) begin
                    if (r_is_write) begin
                        w_state_nxt = ST_WDATA;
                    end else begin
                        w_state_nxt = ST_RDATA;
                        w_tx_load   = 1'b1;
                        w_tx_val    = w_rd_val;
                    end
                end
            end
            ST_WDATA: begin
                if (w_byte_done) begin
                    w_state_nxt = ST_DONE;
                    w_reg_wr    = (r_addr == c_ADDR_PROT) || (r_addr == c_ADDR_CFG);
                end
            end
            ST_RDATA: begin
                // Continuous polling: reload the same register every byte.
                if (w_byte_done) begin
                    w_tx_load = 1'b1;
                    w_tx_val  = w_rd_val;
                end
            end
`ifdef PTMCH_SPI_RESP_JEDEC_EN
            ST_ID_DUMMY: begin
                if (w_byte_done) begin
                    w_state_nxt = ST_ID_OUT;
                    w_tx_load   = 1'b1;
                    w_tx_val    = P_MFR_ID;
                end
            end
            ST_ID_OUT: begin
                if (w_byte_done) begin
                    w_tx_load = 1'b1;
                    case (r_id_idx)
                        2'd1:    w_tx_val = P_DEV_ID[15:8];
                        2'd2:    w_tx_val = P_DEV_ID[7:0];
                        default: w_tx_val = 8'h00;
                    endcase
                end
            end
`endif
            default: w_state_nxt = r_state;
        endcase
    end

`ifdef PTMCH_SPI_RESP_JEDEC_EN
    assign w_tx_active = (r_state == ST_RDATA) || (r_state == ST_ID_OUT);
`else
    assign w_tx_active = (r_state == ST_RDATA);
`endif

    // Frame state: FSM, bit counter, RX shifter, latched address and TX byte.
    always_ff @(posedge SPI_CLK or negedge w_frame_rst_n) begin
        if (!w_frame_rst_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx       <= 8'h00;
            r_addr     <= 8'h00;
            r_tx       <= 8'h00;
            r_is_write <= 1'b0;
            r_wr_stb   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_rx      <= w_byte;
            r_wr_stb  <= w_reg_wr;
            if ((r_state == ST_IDLE) && w_byte_done) begin
                r_is_write <= (w_byte == 8'h1F) || (w_byte == 8'h01);
            end
            if ((r_state == ST_ADDR) && w_byte_done) begin
                r_addr <= w_byte;
            end
            if (w_tx_load) begin
                r_tx <= w_tx_val;
            end
        end
    end

`ifdef PTMCH_SPI_RESP_JEDEC_EN
    // ID byte index: 1 after the manufacturer byte, saturating at 3 (zeros).
    always_ff @(posedge SPI_CLK or negedge w_frame_rst_n) begin
        if (!w_frame_rst_n) begin
            r_id_idx <= 2'd0;
        end else if (w_byte_done) begin
            if (r_state == ST_ID_DUMMY) begin
                r_id_idx <= 2'd1;
            end else if ((r_state == ST_ID_OUT) && (r_id_idx != 2'd3)) begin
                r_id_idx <= r_id_idx + 2'd1;
            end
        end
    end
`endif

    // Persistent registers survive deselect; a raised CS blocks any update.
    always_ff @(posedge SPI_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_prot    <= P_PROT_RST;
            r_cfg     <= P_CFG_RST;
            r_wel     <= 1'b0;
            r_wr_addr <= 8'h00;
        end else if (!SPI_CS) begin
            if (w_wel_set) begin
                r_wel <= 1'b1;
            end
            if (w_wel_clr) begin
                r_wel <= 1'b0;
            end
            if (w_reg_wr) begin
                r_wr_addr <= r_addr;
                if (r_addr == c_ADDR_PROT) begin
                    r_prot <= w_byte;
                end else begin
                    r_cfg <= w_byte;
                end
            end
        end
    end

    // MISO launches on the falling edge so the host samples it on the rising.
    always_ff @(negedge SPI_CLK or negedge w_frame_rst_n) begin
        if (!w_frame_rst_n) begin
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
        end else if (w_tx_active) begin
            r_miso    <= r_tx[~r_bit_cnt];
            r_miso_oe <= 1'b1;
        end else begin
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
        end
    end

    assign SPI_MISO    = r_miso;
    assign SPI_MISO_OE = r_miso_oe;
    assign PROT_REG    = r_prot;
    assign CFG_REG     = r_cfg;
    assign WR_STB      = r_wr_stb;
    assign WR_ADDR     = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_ptmch_spi_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptmch_spi_resp
// Brief    : Self-checking bench for ptmch_spi_resp. Drives SPI mode-0 frames
//            and compares against a register-level reference model.
// Options  : honours PTMCH_SPI_RESP_JEDEC_EN for the Read ID expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptmch_spi_resp;

    logic       RESET_N;
    logic       SPI_CLK;
    logic       SPI_CS;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       SPI_MISO_OE;
    logic       BUSY;
    logic [7:0] PROT_REG;
    logic [7:0] CFG_REG;
    logic       WR_STB;
    logic [7:0] WR_ADDR;

    ptmch_spi_resp dut (
        .RESET_N     (RESET_N),
        .SPI_CLK     (SPI_CLK),
        .SPI_CS      (SPI_CS),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .BUSY        (BUSY),
        .PROT_REG    (PROT_REG),
        .CFG_REG     (CFG_REG),
        .WR_STB      (WR_STB),
        .WR_ADDR     (WR_ADDR)
    );

    initial SPI_CLK = 1'b0;
    always #5 SPI_CLK = ~SPI_CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the register file as seen from the bus.
    logic [7:0] m_prot;
    logic [7:0] m_cfg;
    logic       m_wel;
    logic [7:0] m_wr_addr;

    function automatic logic [7:0] m_read(input logic [7:0] a, input logic busy);
        if (a == 8'hA0)      return m_prot;
        else if (a == 8'hB0) return m_cfg;
        else if (a == 8'hC0) return {6'b0, m_wel, busy};
        else                 return 8'h00;
    endfunction

    function automatic logic m_mapped(input logic [7:0] a);
        return (a == 8'hA0) || (a == 8'hB0);
    endfunction

    function automatic void m_reset();
        m_prot    = 8'h7C;
        m_cfg     = 8'h18;
        m_wel     = 1'b0;
        m_wr_addr = 8'h00;
    endfunction

    // Last per-bit samples and per-byte summaries.
    logic       s_miso, s_oe, s_stb;
    logic [7:0] rx;
    logic       oe_all, oe_any, stb_any;

    // One bit: called just after a falling edge; returns just after the next.
    task automatic bit_x(input logic b);
        SPI_MOSI = b;
        @(posedge SPI_CLK);
        #1;
        s_miso = SPI_MISO;
        s_oe   = SPI_MISO_OE;
        s_stb  = WR_STB;
        @(negedge SPI_CLK);
    endtask

    task automatic byte_x(input logic [7:0] tx, output logic [7:0] r,
                          output logic all_oe, output logic any_oe, output logic any_stb);
        r = 8'h00; all_oe = 1'b1; any_oe = 1'b0; any_stb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bit_x(tx[i]);
            r[i]    = s_miso;
            all_oe  = all_oe & s_oe;
            any_oe  = any_oe | s_oe;
            any_stb = any_stb | s_stb;
        end
    endtask

    task automatic cs_lo();
        @(negedge SPI_CLK);
        SPI_CS = 1'b0;
    endtask

    // Deselect at a falling edge; outputs are sampled 1 ns later by callers.
    task automatic cs_hi();
        SPI_CS   = 1'b1;
        SPI_MOSI = 1'b0;
        #1;
    endtask

    task automatic gap();
        repeat (2) @(negedge SPI_CLK);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; SPI_CS = 1'b1; SPI_MOSI = 1'b0; BUSY = 1'b0;
        m_reset();
        repeat (3) @(negedge SPI_CLK);
        n_checks++; if (SPI_MISO !== 1'b0)    $display("FAIL rst_miso: got %b exp 0", SPI_MISO);        else n_pass++;
        n_checks++; if (SPI_MISO_OE !== 1'b0) $display("FAIL rst_oe: got %b exp 0", SPI_MISO_OE);       else n_pass++;
        n_checks++; if (WR_STB !== 1'b0)      $display("FAIL rst_stb: got %b exp 0", WR_STB);            else n_pass++;
        n_checks++; if (WR_ADDR !== 8'h00)    $display("FAIL rst_wr_addr: got %h exp 00", WR_ADDR);      else n_pass++;
        n_checks++; if (PROT_REG !== 8'h7C)   $display("FAIL rst_prot: got %h exp 7c", PROT_REG);        else n_pass++;
        n_checks++; if (CFG_REG !== 8'h18)    $display("FAIL rst_cfg: got %h exp 18", CFG_REG);          else n_pass++;
        RESET_N = 1'b1;
        gap();
    endtask

    // Generic status read: busy_seq[k] is BUSY while byte k is loaded.
    task automatic do_read(input logic [7:0] op, input logic [7:0] a, input int nb,
                           input logic [3:0] busy_seq, input string tag);
        logic [7:0] exp;
        BUSY = busy_seq[0];
        cs_lo();
        byte_x(op, rx, oe_all, oe_any, stb_any);
        byte_x(a, rx, oe_all, oe_any, stb_any);
        n_checks++; if (oe_any !== 1'b0) $display("FAIL %s_oe_early: got %b exp 0", tag, oe_any); else n_pass++;
        for (int k = 0; k < nb; k++) begin
            exp  = m_read(a, busy_seq[k]);
            BUSY = busy_seq[k+1];
            byte_x(8'($urandom), rx, oe_all, oe_any, stb_any);
            n_checks++; if (rx !== exp)      $display("FAIL %s_byte%0d: got %h exp %h", tag, k, rx, exp); else n_pass++;
            n_checks++; if (oe_all !== 1'b1) $display("FAIL %s_oe%0d: got %b exp 1", tag, k, oe_all);    else n_pass++;
        end
        cs_hi();
        n_checks++; if (SPI_MISO_OE !== 1'b0) $display("FAIL %s_oe_cs: got %b exp 0", tag, SPI_MISO_OE); else n_pass++;
        gap();
    endtask

    task automatic test_read_status();
        do_read(8'h0F, 8'hA0, 2, 4'b0000, "rd_prot");
        do_read(8'h05, 8'hB0, 1, 4'b0000, "rd_cfg");
    endtask

    // Full write; when early_cs, deselect right after edge 24.
    task automatic do_write(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                            input logic early_cs, input string tag);
        logic mapped;
        mapped = m_mapped(a);
        cs_lo();
        byte_x(op, rx, oe_all, oe_any, stb_any);
        byte_x(a, rx, oe_all, oe_any, stb_any);
        n_checks++; if (stb_any !== 1'b0) $display("FAIL %s_stb_early: got %b exp 0", tag, stb_any); else n_pass++;
        byte_x(d, rx, oe_all, oe_any, stb_any);
        n_checks++; if (s_stb !== mapped) $display("FAIL %s_stb24: got %b exp %b", tag, s_stb, mapped); else n_pass++;
        n_checks++; if (oe_any !== 1'b0)  $display("FAIL %s_oe: got %b exp 0", tag, oe_any);           else n_pass++;
        if (mapped) begin
            if (a == 8'hA0) m_prot = d; else m_cfg = d;
            m_wr_addr = a;
        end
        if (early_cs) begin
            cs_hi();
            n_checks++; if (WR_STB !== 1'b0) $display("FAIL %s_stb_cs: got %b exp 0", tag, WR_STB); else n_pass++;
        end else begin
            bit_x(1'b0);
            n_checks++; if (s_stb !== 1'b0) $display("FAIL %s_stb25: got %b exp 0", tag, s_stb); else n_pass++;
            cs_hi();
        end
        n_checks++; if (WR_ADDR !== m_wr_addr) $display("FAIL %s_wr_addr: got %h exp %h", tag, WR_ADDR, m_wr_addr); else n_pass++;
        n_checks++; if (PROT_REG !== m_prot)   $display("FAIL %s_prot: got %h exp %h", tag, PROT_REG, m_prot);      else n_pass++;
        n_checks++; if (CFG_REG !== m_cfg)     $display("FAIL %s_cfg: got %h exp %h", tag, CFG_REG, m_cfg);         else n_pass++;
        gap();
    endtask

    task automatic test_write();
        do_write(8'h1F, 8'hB0, 8'h5A, 1'b0, "wr_cfg");
        do_read(8'h0F, 8'hB0, 1, 4'b0000, "rd_after_wr");
        do_write(8'h01, 8'hA0, 8'($urandom), 1'b1, "wr_prot_cs");
        do_read(8'h0F, 8'hA0, 1, 4'b0000, "rd_prot2");
    endtask

    task automatic send_op(input logic [7:0] op);
        cs_lo();
        byte_x(op, rx, oe_all, oe_any, stb_any);
        cs_hi();
        if (op == 8'h06) m_wel = 1'b1;
        if (op == 8'h04) m_wel = 1'b0;
        gap();
    endtask

    task automatic test_wel_busy();
        send_op(8'h06);
        do_read(8'h0F, 8'hC0, 2, 4'b0001, "stat_wel");
        send_op(8'h04);
        do_read(8'h0F, 8'hC0, 1, 4'b0000, "stat_clr");
    endtask

    task automatic test_abort();
        cs_lo();
        byte_x(8'h1F, rx, oe_all, oe_any, stb_any);
        byte_x(8'hA0, rx, oe_all, oe_any, stb_any);
        for (int i = 0; i < 4; i++) bit_x(1'b1);
        cs_hi();
        n_checks++; if (s_stb !== 1'b0)        $display("FAIL abort_stb: got %b exp 0", s_stb);           else n_pass++;
        n_checks++; if (SPI_MISO_OE !== 1'b0)  $display("FAIL abort_oe: got %b exp 0", SPI_MISO_OE);     else n_pass++;
        n_checks++; if (PROT_REG !== m_prot)   $display("FAIL abort_prot: got %h exp %h", PROT_REG, m_prot); else n_pass++;
        gap();
        // Abort mid read: OE and MISO must drop without a clock.
        m_prot = m_prot;
        cs_lo();
        byte_x(8'h0F, rx, oe_all, oe_any, stb_any);
        byte_x(8'hC0, rx, oe_all, oe_any, stb_any);
        BUSY = 1'b1;
        for (int i = 0; i < 3; i++) bit_x(1'b0);
        cs_hi();
        n_checks++; if ({SPI_MISO_OE, SPI_MISO} !== 2'b00) $display("FAIL abort_rd: got %b exp 00", {SPI_MISO_OE, SPI_MISO}); else n_pass++;
        BUSY = 1'b0;
        gap();
    endtask

    task automatic test_read_id();
        logic [7:0] exp_id [4];
        exp_id[0] = 8'hEF; exp_id[1] = 8'hAA; exp_id[2] = 8'h21; exp_id[3] = 8'h00;
        cs_lo();
        byte_x(8'h9F, rx, oe_all, oe_any, stb_any);
        byte_x(8'h00, rx, oe_all, oe_any, stb_any);
        n_checks++; if (oe_any !== 1'b0) $display("FAIL id_dummy_oe: got %b exp 0", oe_any); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            byte_x(8'($urandom), rx, oe_all, oe_any, stb_any);
`ifdef PTMCH_SPI_RESP_JEDEC_EN
            n_checks++; if (rx !== exp_id[k < 4 ? k : 3]) $display("FAIL id_byte%0d: got %h exp %h", k, rx, exp_id[k < 4 ? k : 3]); else n_pass++;
            n_checks++; if (oe_all !== 1'b1) $display("FAIL id_oe%0d: got %b exp 1", k, oe_all); else n_pass++;
`else
            n_checks++; if (oe_any !== 1'b0) $display("FAIL id_off_oe%0d: got %b exp 0 (%h)", k, oe_any, exp_id[0]); else n_pass++;
`endif
        end
        cs_hi();
        gap();
    endtask

    task automatic test_unmapped();
        do_write(8'h1F, 8'hC0, 8'hFF, 1'b0, "wr_stat");
        do_read(8'h0F, 8'hC0, 2, 4'b0010, "stat_after");
        cs_lo();
        for (int k = 0; k < 3; k++) begin
            byte_x(k == 0 ? 8'h3B : 8'($urandom), rx, oe_all, oe_any, stb_any);
            n_checks++; if (oe_any !== 1'b0)  $display("FAIL unk_oe%0d: got %b exp 0", k, oe_any);   else n_pass++;
            n_checks++; if (stb_any !== 1'b0) $display("FAIL unk_stb%0d: got %b exp 0", k, stb_any); else n_pass++;
        end
        cs_hi();
        gap();
    endtask

    task automatic test_random();
        logic [7:0] a, op;
        int         kind;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 4);
            case ($urandom_range(0, 3))
                0:       a = 8'hA0;
                1:       a = 8'hB0;
                2:       a = 8'hC0;
                default: a = 8'($urandom);
            endcase
            case (kind)
                0: do_read($urandom_range(0, 1) ? 8'h0F : 8'h05, a, $urandom_range(1, 3),
                           4'($urandom), "rnd_rd");
                1: do_write($urandom_range(0, 1) ? 8'h1F : 8'h01, a, 8'($urandom),
                            1'($urandom_range(0, 1)), "rnd_wr");
                2: send_op($urandom_range(0, 1) ? 8'h06 : 8'h04);
                3: begin
                    do op = 8'($urandom);
                    while (op inside {8'h0F, 8'h05, 8'h1F, 8'h01, 8'h06, 8'h04, 8'h9F});
                    cs_lo();
                    byte_x(op, rx, oe_all, oe_any, stb_any);
                    byte_x(a, rx, oe_all, oe_any, stb_any);
                    byte_x(8'($urandom), rx, oe_all, oe_any, stb_any);
                    n_checks++; if ({oe_any, stb_any} !== 2'b00) $display("FAIL rnd_unk %h: got %b exp 00", op, {oe_any, stb_any}); else n_pass++;
                    cs_hi();
                    gap();
                end
                default: begin
                    cs_lo();
                    byte_x(8'h1F, rx, oe_all, oe_any, stb_any);
                    byte_x(a, rx, oe_all, oe_any, stb_any);
                    for (int i = 0; i < $urandom_range(0, 7); i++) bit_x(1'($urandom));
                    cs_hi();
                    n_checks++; if ({PROT_REG, CFG_REG} !== {m_prot, m_cfg}) $display("FAIL rnd_abort: got %h exp %h", {PROT_REG, CFG_REG}, {m_prot, m_cfg}); else n_pass++;
                    n_checks++; if (WR_STB !== 1'b0) $display("FAIL rnd_abort_stb: got %b exp 0", WR_STB); else n_pass++;
                    gap();
                end
            endcase
        end
        // Status register confirms the accumulated WEL state.
        do_read(8'h0F, 8'hC0, 1, 4'b0000, "rnd_wel");
    endtask

    task automatic test_reset_mid();
        do_write(8'h1F, 8'hA0, 8'h3C, 1'b0, "pre_rst");
        send_op(8'h06);
        cs_lo();
        byte_x(8'h0F, rx, oe_all, oe_any, stb_any);
        byte_x(8'hA0, rx, oe_all, oe_any, stb_any);
        for (int i = 0; i < 3; i++) bit_x(1'b0);
        RESET_N = 1'b0;
        #1;
        m_reset();
        n_checks++; if (SPI_MISO_OE !== 1'b0) $display("FAIL mid_rst_oe: got %b exp 0", SPI_MISO_OE); else n_pass++;
        n_checks++; if (PROT_REG !== m_prot)  $display("FAIL mid_rst_prot: got %h exp %h", PROT_REG, m_prot); else n_pass++;
        n_checks++; if (WR_ADDR !== 8'h00)    $display("FAIL mid_rst_wr_addr: got %h exp 00", WR_ADDR); else n_pass++;
        @(negedge SPI_CLK);
        cs_hi();
        RESET_N = 1'b1;
        gap();
        do_read(8'h0F, 8'hC0, 1, 4'b0000, "post_rst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_status();
        test_write();
        test_wel_busy();
        test_abort();
        test_read_id();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ptmch_spi_resp.md
# ptmch_spi_resp

SPI-NAND responder that models the status-register and identification subset of the flash command set on the far end of the SPI bus monitored by the trigger logic. It decodes opcodes on SPI_MOSI, maintains the protection, configuration and status registers, and drives SPI_MISO so the FPGA can stand in for a real flash device on the DE0-Nano test harness. All logic runs in the SPI_CLK domain, with SPI_CS acting as an asynchronous transaction frame.

## Interface
- P_MFR_ID, 8'hEF: JEDEC manufacturer ID byte.
- P_DEV_ID, 16'hAA21: JEDEC device ID, MSB byte first.
- P_PROT_RST, 8'h7C: reset value of the protection register (address A0h).
- P_CFG_RST, 8'h18: reset value of the configuration register (address B0h).

- RESET_N  input  1  reset, asynchronous, active-low
- SPI_CLK  input  1  clock
- SPI_CS  input  1  chip select, active-low; high asynchronously aborts the transaction and returns to IDLE
- SPI_MOSI  input  1  serial command/address/data, sampled on rising SPI_CLK
- SPI_MISO  output  1  serial read data, updated on falling SPI_CLK
- SPI_MISO_OE  output  1  MISO drive enable for the top-level tristate
- BUSY  input  1  quasi-static busy flag, reported as bit 0 of status register C0h
- PROT_REG  output  8  protection register contents
- CFG_REG  output  8  configuration register contents
- WR_STB  output  1  one-cycle pulse on a successful register write
- WR_ADDR  output  8  address of the last written register

## Operation
- Mode 0, MSB first. The 3-bit bit counter and the 8-bit RX shift register both clear asynchronously while SPI_CS is high.
- States: IDLE (opcode) -> ADDR -> WDATA | RDATA; IDLE -> ID_DUMMY -> ID_OUT; any state -> DONE (ignores remaining clocks).
- Opcode decode at rising edge 8:
  - 0Fh / 05h: Read Status. Go to ADDR.
  - 1Fh / 01h: Write Status. Go to ADDR.
  - 06h: set WEL. Go to DONE.
  - 04h: clear WEL. Go to DONE.
  - 9Fh: Read ID. Go to ID_DUMMY.
  - Any other opcode: go to DONE; MISO_OE stays 0.
- Register map:
  - A0h: PROT_REG, read/write.
  - B0h: CFG_REG, read/write.
  - C0h: status, read-only, value {6'b0, WEL, BUSY}.
  - Any other address: reads 00h, writes are ignored.
- Read Status (RDATA):
  - The address is latched at rising edge 16 and the TX byte is loaded from the register at that edge.
  - One bit is shifted out per falling edge, MSB first.
  - Every 8 bits the byte is reloaded from the same address (continuous polling). BUSY and WEL are re-sampled at each reload.
- Write Status (WDATA):
  - At rising edge 24, the data byte is written to A0h or B0h. WR_STB=1 and WR_ADDR is set to the address. Then go to DONE.
  - Writes to C0h or unmapped addresses: no update and no WR_STB. Go to DONE.
  - CS rising before edge 24: no update.
  - No WEL requirement.
- Read ID:
  - ID_DUMMY consumes 8 clocks.
  - ID_OUT drives P_MFR_ID, P_DEV_ID[15:8], P_DEV_ID[7:0], then 00h for all further bytes.
- WEL is not cleared by CS. PROT_REG, CFG_REG and WEL are cleared only by RESET_N.

## Timing
- Reset values:
  - SPI_MISO=0, SPI_MISO_OE=0, WR_STB=0, WR_ADDR=00h.
  - PROT_REG=P_PROT_RST, CFG_REG=P_CFG_RST, WEL=0.
  - State=IDLE.
- Read Status latency: the first data bit (bit 7) appears on SPI_MISO at the falling edge following rising edge 16, valid for host sampling at rising edge 17.
- SPI_MISO_OE:
  - Rises at that same falling edge (Read Status), or after rising edge 16 (Read ID).
  - Falls asynchronously when SPI_CS goes high; SPI_MISO is also forced to 0 at the same time.
- WR_STB is high for exactly one SPI_CLK cycle, from rising edge 24 to rising edge 25. It is also cleared asynchronously by SPI_CS high if no further clocks arrive.
- PROT_REG and CFG_REG change at rising edge 24. A read of the same register in a later transaction returns the new value.
- RESET_N asserted mid-transaction: immediate return to all reset values. Deasserting RESET_N while CS is low leaves the block in IDLE and the remainder of the frame is decoded as a new opcode. The bench releases RESET_N only with CS high.
- Simultaneous CS rise and SPI_CLK edge: CS wins; no register update.

## Configuration
- PTMCH_SPI_RESP_JEDEC_EN:
  - Defined: opcode 9Fh and the ID_DUMMY/ID_OUT states are built.
  - Undefined: 9Fh decodes as an unknown opcode (DONE, MISO_OE=0), and the P_MFR_ID/P_DEV_ID parameters are unused.

## Test plan
- Reset, then CS low, send 0Fh A0h, clock 16 more bits -> MISO shows 7Ch twice; OE high from the falling edge after edge 16.
- Send 1Fh B0h 5Ah -> WR_STB pulses at edge 24 with WR_ADDR=B0h; CFG_REG=5Ah; a following 0Fh B0h read returns 5Ah.
- Send 06h, then 0Fh C0h with BUSY=1 for byte 1 and BUSY=0 for byte 2 -> MISO bytes 03h then 02h; then send 04h and repeat the read -> 00h.
- Send 1Fh A0h, raise CS after 20 bits -> PROT_REG unchanged at 7Ch, no WR_STB, MISO_OE=0 immediately.
- With PTMCH_SPI_RESP_JEDEC_EN defined, send 9Fh + 8 dummy clocks + 32 clocks -> EFh AAh 21h 00h; with it undefined -> MISO_OE stays 0.
- Send 1Fh C0h FFh, then unknown opcode 3Bh -> no WR_STB, status read still {6'b0, WEL, BUSY}, MISO_OE=0 throughout the 3Bh frame.
